// File: rtl/y86_pkg.sv
// Shared types and constants for the sequential Y86-64 controller: FSM states,
// status codes, instruction classes and stage-enable bit positions.
package y86_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam int SE_FETCH  = 0;
  localparam int SE_DECODE = 1;
  localparam int SE_EXEC   = 2;
  localparam int SE_MEM    = 3;
  localparam int SE_WB     = 4;
  localparam int SE_PCUPD  = 5;

  // Instructions that touch data memory (loads, stores and stack operations).
  function automatic logic uses_dmem(input logic [3:0] ic);
    case (ic)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module y86_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/y86_seq_controller.sv
// Sequencing FSM for the sequential Y86-64 core: walks each instruction through
// its stages, runs the memory handshakes and owns pc, status and perf counters.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int                PC_W       = 64,
  parameter logic [PC_W-1:0]   RESET_PC   = '0,
  parameter int unsigned       IMEM_LIMIT = 20480,
  parameter int                CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  input  logic [PC_W-1:0]  new_pc,
  output logic [PC_W-1:0]  pc,
  output logic [5:0]       stage_en,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  state_t          state_q, state_d;
  stat_t           stat_q, stat_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      icode_q, icode_d;
  logic            pc_fault;
  logic            cycle_inc;
  logic            retire_inc;

  assign pc_fault = (pc_q > PC_W'(IMEM_LIMIT));

  always_comb begin
    state_d    = state_q;
    stat_d     = stat_q;
    pc_d       = pc_q;
    icode_d    = icode_q;
    stage_en   = '0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    retire_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An out-of-range pc faults without ever touching instruction memory.
        if (pc_fault) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          imem_req           = 1'b1;
          stage_en[SE_FETCH] = 1'b1;
          if (imem_ack) begin
            icode_d = icode;
            if (imem_error) begin
              stat_d  = STAT_ADR;
              state_d = S_HALT;
            end else if (!instr_valid) begin
              stat_d  = STAT_INS;
              state_d = S_HALT;
            end else if (icode == IHALT) begin
              stat_d  = STAT_HLT;
              state_d = S_HALT;
            end else begin
              state_d = S_DECODE;
            end
          end
        end
      end
      S_DECODE: begin
        stage_en[SE_DECODE] = 1'b1;
        state_d             = S_EXECUTE;
      end
      S_EXECUTE: begin
        stage_en[SE_EXEC] = 1'b1;
        state_d           = uses_dmem(icode_q) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req         = 1'b1;
        stage_en[SE_MEM] = 1'b1;
        if (dmem_ack) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        stage_en[SE_WB] = 1'b1;
        state_d         = S_PCUPD;
      end
      S_PCUPD: begin
        stage_en[SE_PCUPD] = 1'b1;
        pc_d               = new_pc;
        retire_inc         = 1'b1;
        state_d            = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      pc_q    <= RESET_PC;
      icode_q <= IHALT;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      pc_q    <= pc_d;
      icode_q <= icode_d;
    end
  end

  assign cycle_inc = (state_q != S_IDLE) && (state_q != S_HALT);

  y86_sat_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk   (clk),
    .clear (reset),
    .inc   (cycle_inc),
    .count (cycles)
  );

  y86_sat_counter #(.CNT_W(CNT_W)) u_retired (
    .clk   (clk),
    .clear (reset),
    .inc   (retire_inc),
    .count (retired)
  );

  assign pc     = pc_q;
  assign stat   = stat_q;
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_y86_seq_controller.sv
// Scoreboard bench for y86_seq_controller: stimulus queues the expected per-cycle
// outputs, a negedge monitor pops and compares whenever the DUT shows activity.
module tb_y86_seq_controller;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             imem_req;
  logic             imem_ack;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             dmem_req;
  logic             dmem_ack;
  logic             dmem_error;
  logic [63:0]      new_pc;
  logic [63:0]      pc;
  logic [5:0]       stage_en;
  logic [2:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  y86_seq_controller #(
    .PC_W       (64),
    .RESET_PC   (64'd0),
    .IMEM_LIMIT (20480),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .dmem_error  (dmem_error),
    .new_pc      (new_pc),
    .pc          (pc),
    .stage_en    (stage_en),
    .stat        (stat),
    .halted      (halted),
    .cycles      (cycles),
    .retired     (retired)
  );

  typedef struct {
    logic [5:0]  se;
    logic        ireq;
    logic        dreq;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        halted;
    logic [7:0]  ret;
    logic [7:0]  cyc;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        probe = 1'b0;
  logic        halted_prev = 1'b0;
  logic [63:0] m_pc;
  logic [2:0]  m_stat;
  logic [7:0]  m_ret;
  logic [7:0]  m_cyc;
  string       cur_tag;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic is_mem(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per observable cycle.
  always @(negedge clk) begin
    exp_t e;
    if ((stage_en != 6'd0) || (halted && !halted_prev) || probe) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got stage_en=%0h halted=%0b, expected no activity",
                 stage_en, halted);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.tag, ".stage_en"}, 64'(stage_en), 64'(e.se));
        checkOutput({e.tag, ".imem_req"}, 64'(imem_req), 64'(e.ireq));
        checkOutput({e.tag, ".dmem_req"}, 64'(dmem_req), 64'(e.dreq));
        checkOutput({e.tag, ".pc"},       pc,            e.pc);
        checkOutput({e.tag, ".stat"},     64'(stat),     64'(e.stat));
        checkOutput({e.tag, ".halted"},   64'(halted),   64'(e.halted));
        checkOutput({e.tag, ".retired"},  64'(retired),  64'(e.ret));
        checkOutput({e.tag, ".cycles"},   64'(cycles),   64'(e.cyc));
      end
    end
    halted_prev = halted;
  end

  task automatic push_exp(input logic [5:0] se, input logic ireq, input logic dreq, input logic hlt);
    exp_t e;
    e.se = se; e.ireq = ireq; e.dreq = dreq; e.pc = m_pc; e.stat = m_stat;
    e.halted = hlt; e.ret = m_ret; e.cyc = m_cyc; e.tag = cur_tag;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_active();
    tick();
    m_cyc = sat_inc(m_cyc);
  endtask

  task automatic model_reset();
    m_pc = 64'd0; m_stat = 3'd1; m_ret = 8'd0; m_cyc = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; icode = 4'h0; instr_valid = 1'b0;
    imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0; new_pc = 64'd0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    probe = 1'b1;
    push_exp(6'h00, 1'b0, 1'b0, 1'b0);
    tick();
    probe = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction starting in a FETCH cycle and queues every cycle's outputs.
  task automatic applyStimulus(input logic [3:0] ic, input logic valid, input logic ierr,
                               input int iwait, input int dwait, input logic derr,
                               input logic rst_mem, input logic [63:0] npc);
    logic last;
    if (m_pc > 64'd20480) begin
      probe = 1'b1;
      push_exp(6'h00, 1'b0, 1'b0, 1'b0);
      step_active();
      probe = 1'b0;
      m_stat = 3'd3;
      push_exp(6'h00, 1'b0, 1'b0, 1'b1);
      tick();
      return;
    end
    for (int w = 0; w <= iwait; w++) begin
      last        = (w == iwait);
      imem_ack    = last;
      icode       = last ? ic : 4'hF;
      instr_valid = last ? valid : 1'b0;
      imem_error  = last ? ierr : 1'b0;
      push_exp(6'h01, 1'b1, 1'b0, 1'b0);
      step_active();
    end
    imem_ack = 1'b0; imem_error = 1'b0; instr_valid = 1'b0;
    icode = is_mem(ic) ? 4'h0 : 4'h5;
    if (ierr || !valid || (ic == 4'h0)) begin
      m_stat = ierr ? 3'd3 : (!valid ? 3'd4 : 3'd2);
      push_exp(6'h00, 1'b0, 1'b0, 1'b1);
      tick();
      return;
    end
    push_exp(6'h02, 1'b0, 1'b0, 1'b0);
    step_active();
    push_exp(6'h04, 1'b0, 1'b0, 1'b0);
    step_active();
    if (is_mem(ic)) begin
      for (int w = 0; w <= dwait; w++) begin
        last       = (w == dwait);
        dmem_ack   = last;
        dmem_error = last ? derr : 1'b1;
        push_exp(6'h08, 1'b0, 1'b1, 1'b0);
        if (rst_mem) begin
          reset = 1'b1;
          tick();
          reset = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
          model_reset();
          probe = 1'b1;
          push_exp(6'h00, 1'b0, 1'b0, 1'b0);
          tick();
          probe = 1'b0;
          return;
        end
        step_active();
      end
      dmem_ack = 1'b0; dmem_error = 1'b0;
      if (derr) begin
        m_stat = 3'd3;
        push_exp(6'h00, 1'b0, 1'b0, 1'b1);
        tick();
        return;
      end
    end
    push_exp(6'h10, 1'b0, 1'b0, 1'b0);
    step_active();
    new_pc = npc;
    push_exp(6'h20, 1'b0, 1'b0, 1'b0);
    step_active();
    m_ret = sat_inc(m_ret);
    m_pc  = npc;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] ic;
    reset = 1'b0; start = 1'b0; imem_ack = 1'b0; icode = 4'h0; instr_valid = 1'b0;
    imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0; new_pc = 64'd0;
    model_reset();

    cur_tag = "reset";
    do_reset();
    start_pulse();
    cur_tag = "irmovq";
    applyStimulus(4'h3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 64'd10);
    cur_tag = "mrmovq_wait";
    applyStimulus(4'h5, 1'b1, 1'b0, 0, 3, 1'b0, 1'b0, 64'd20);
    cur_tag = "opq_iwait";
    applyStimulus(4'h6, 1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 64'h20);
    cur_tag = "halt";
    applyStimulus(4'h0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 64'h99);
    cur_tag = "start_in_halt";
    start_pulse();
    probe = 1'b1;
    push_exp(6'h00, 1'b0, 1'b0, 1'b1);
    tick();
    probe = 1'b0;

    cur_tag = "adr_wins";
    do_reset();
    start_pulse();
    applyStimulus(4'h6, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 64'd0);
    cur_tag = "ins";
    do_reset();
    start_pulse();
    applyStimulus(4'h6, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 64'd0);

    cur_tag = "pc_over_limit";
    do_reset();
    start_pulse();
    applyStimulus(4'h3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 64'd20481);
    applyStimulus(4'h1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 64'd0);

    cur_tag = "pc_at_limit";
    do_reset();
    start_pulse();
    applyStimulus(4'h3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 64'd20480);
    applyStimulus(4'h6, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 64'd30);
    cur_tag = "dmem_error";
    applyStimulus(4'h8, 1'b1, 1'b0, 0, 1, 1'b1, 1'b0, 64'd40);

    cur_tag = "reset_in_mem";
    do_reset();
    start_pulse();
    applyStimulus(4'h4, 1'b1, 1'b0, 4, 5, 1'b0, 1'b1, 64'd50);

    cur_tag = "saturate";
    start_pulse();
    for (int i = 0; i < 260; i++) begin
      case (i % 5)
        0: ic = 4'h1;
        1: ic = 4'h2;
        2: ic = 4'h3;
        3: ic = 4'h6;
        default: ic = 4'h7;
      endcase
      if ((i % 4) == 3) ic = 4'hA;
      applyStimulus(ic, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, m_pc + 64'd10);
    end
    cur_tag = "saturate_halt";
    applyStimulus(4'h0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 64'd0);

    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL leftover_expectations: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
